// File: rtl/uart_cmd_pkg.sv
// Shared constants, state type and byte classifiers for the UART command decoder.
package uart_cmd_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_m  = 8'h6D;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam int ACC_W = 10;
    localparam int MAX_DIGITS = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NUM  = 2'd1,
        ERR  = 2'd2
    } cmd_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == CH_CR) || (b == CH_LF);
    endfunction

    function automatic logic is_frame_start(input logic [7:0] b);
        return (b == CH_M) || (b == CH_m);
    endfunction

    function automatic logic [3:0] digit_val(input logic [7:0] b);
        logic [7:0] d;
        d = b - CH_0;
        return d[3:0];
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Falling-edge detector on the receiver busy flag; presents the received byte
// alongside a one-cycle strobe so the consumer registers it on the strobe edge.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic       busy_i,
    input  logic [7:0] data_i,
    output logic       strobe_o,
    output logic [7:0] data_o
);

    logic busy_q;

    // Reset to 1 so the first strobe needs a genuine high->low transition
    // seen while out of reset, not the reset release itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b1;
        end else begin
            busy_q <= busy_i;
        end
    end

    assign strobe_o = busy_q & ~busy_i;
    assign data_o   = data_i;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes legacy single-digit and framed "M<digits><CR|LF>" commands into a
// validated harmonic multiplier M with a one-cycle Sync pulse on each update.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int M_W            = 6,
    parameter int MAX_M          = 63,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic           Clk_100M,
    input  logic           Reset,
    input  logic [7:0]     dataR,
    input  logic           busyR,
    output logic [M_W-1:0] M,
    output logic           Sync,
    output logic           Err,
    output logic           Busy
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ACC_W-1:0] MAX_ACC  = ACC_W'(MAX_M);

    logic             strobe;
    logic [7:0]       rx_byte;

    cmd_state_t       state_q;
    logic [M_W-1:0]   m_q;
    logic             sync_q;
    logic             err_q;
    logic             busy_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [1:0]       dcnt_q;
    logic [TMO_W-1:0] tmo_q;

    logic             b_digit;
    logic             b_term;
    logic             b_start;
    logic [3:0]       b_val;
    logic             acc_ok;
    logic             tmo_hit;

    uart_byte_strobe u_strobe (
        .clk      (Clk_100M),
        .rst      (Reset),
        .busy_i   (busyR),
        .data_i   (dataR),
        .strobe_o (strobe),
        .data_o   (rx_byte)
    );

    always_comb begin
        b_digit = is_digit(rx_byte);
        b_term  = is_term(rx_byte);
        b_start = is_frame_start(rx_byte);
        b_val   = digit_val(rx_byte);
        // Only evaluated with at most two digits held, so 99*10+9 fits in ACC_W.
        acc_d   = acc_q * ACC_W'(10) + ACC_W'(b_val);
        // Range check at full accumulator width, before narrowing to M_W.
        acc_ok  = (dcnt_q != 2'd0) && (acc_q != '0) && (acc_q <= MAX_ACC);
        tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LAST);
    end

    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            tmo_q <= '0;
        end else if (strobe || (state_q == IDLE) || tmo_hit) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            m_q     <= M_W'(1);
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            acc_q   <= '0;
            dcnt_q  <= 2'd0;
        end else begin
            sync_q <= 1'b0;
            err_q  <= 1'b0;
            // A byte arriving on the timeout cycle takes priority over the timeout.
            if (strobe) begin
                case (state_q)
                    IDLE: begin
                        if (b_digit && (b_val != 4'd0)) begin
                            m_q    <= M_W'(b_val);
                            sync_q <= 1'b1;
                        end else if (b_start) begin
                            acc_q   <= '0;
                            dcnt_q  <= 2'd0;
                            state_q <= NUM;
                            busy_q  <= 1'b1;
                        end
                    end
                    NUM: begin
                        if (b_digit) begin
                            if (dcnt_q == 2'(MAX_DIGITS)) begin
                                state_q <= ERR;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else begin
                                acc_q  <= acc_d;
                                dcnt_q <= dcnt_q + 2'd1;
                            end
                        end else if (b_term) begin
                            if (acc_ok) begin
                                m_q    <= M_W'(acc_q);
                                sync_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            acc_q   <= '0;
                            dcnt_q  <= 2'd0;
                        end else begin
                            state_q <= ERR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                    ERR: begin
                        if (b_term) begin
                            state_q <= IDLE;
                            acc_q   <= '0;
                            dcnt_q  <= 2'd0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end else if (tmo_hit) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                acc_q   <= '0;
                dcnt_q  <= 2'd0;
            end
        end
    end

    assign M    = m_q;
    assign Sync = sync_q;
    assign Err  = err_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with a pulse scoreboard checked on every falling clock edge.
module tb_uart_cmd_decoder;

    localparam int M_W   = 6;
    localparam int MAX_M = 63;
    localparam int TMO   = 40;

    logic           clk;
    logic           rst;
    logic [7:0]     dataR;
    logic           busyR;
    logic [M_W-1:0] M;
    logic           Sync;
    logic           Err;
    logic           Busy;

    typedef struct {
        logic [1:0]     pulse;   // {Sync, Err}
        logic [M_W-1:0] m;
        int             cyc;
    } exp_t;

    exp_t           exp_q[$];
    int             total = 0;
    int             bad   = 0;
    int             cyc   = 0;
    logic [M_W-1:0] m_model = M_W'(1);

    localparam int NONE = 0;
    localparam int SYNC = 1;
    localparam int ERRP = 2;

    uart_cmd_decoder #(
        .M_W            (M_W),
        .MAX_M          (MAX_M),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk_100M (clk),
        .Reset    (rst),
        .dataR    (dataR),
        .busyR    (busyR),
        .M        (M),
        .Sync     (Sync),
        .Err      (Err),
        .Busy     (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output pulse must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        if (!rst && (Sync === 1'b1 || Err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                total++;
                assert ({Sync, Err} === 2'b00) else begin
                    bad++;
                    $error("FAIL unexpected_pulse cyc=%0d obs={Sync,Err}=%b exp=00", cyc, {Sync, Err});
                end
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                total++;
                assert ({Sync, Err} === e.pulse && M === e.m && cyc === e.cyc) else begin
                    bad++;
                    $error("FAIL pulse obs={Sync,Err}=%b M=%0d cyc=%0d exp=%b M=%0d cyc=%0d",
                           {Sync, Err}, M, cyc, e.pulse, e.m, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    // Receiver busy for 3 cycles, then low for one cycle (back-to-back capable).
    task automatic send_byte(input logic [7:0] b, input int kind, input int new_m);
        exp_t e;
        busyR = 1'b1;
        repeat (3) @(negedge clk);
        dataR = b;
        busyR = 1'b0;
        if (kind == SYNC) begin
            m_model = M_W'(new_m);
            e.pulse = 2'b10;
        end else if (kind == ERRP) begin
            e.pulse = 2'b01;
        end
        if (kind != NONE) begin
            e.m   = m_model;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        $display("byte 0x%02h kind=%0d M=%0d Sync=%b Err=%b Busy=%b", b, kind, M, Sync, Err, Busy);
    endtask

    task automatic send_quiet(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], NONE, 0);
    endtask

    initial begin
        rst   = 1'b1;
        busyR = 1'b1;
        dataR = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_M", int'(M), 1);
        chk("reset_Sync", int'(Sync), 0);
        chk("reset_Err", int'(Err), 0);
        chk("reset_Busy", int'(Busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_false_strobe_M", int'(M), 1);

        // Legacy single digit
        send_byte("5", SYNC, 5);
        chk("legacy5_M", int'(M), 5);
        chk("legacy5_Busy", int'(Busy), 0);
        send_quiet("0");
        chk("zero_ignored", int'(M), 5);

        // Framed 42
        send_byte("M", NONE, 0);
        chk("m42_busy_after_M", int'(Busy), 1);
        send_quiet("42");
        chk("m42_M_held", int'(M), 5);
        chk("m42_busy_mid", int'(Busy), 1);
        send_byte(8'h0D, SYNC, 42);
        chk("m42_M", int'(M), 42);
        chk("m42_busy_end", int'(Busy), 0);

        // Rejected frames
        send_quiet("M64");
        send_byte(8'h0A, ERRP, 0);
        send_quiet("M0");
        send_byte(8'h0D, ERRP, 0);
        send_quiet("M");
        send_byte(8'h0D, ERRP, 0);
        chk("rejects_M_held", int'(M), 42);

        // Upper boundary accepted with three digits, lowercase start
        send_quiet("m063");
        send_byte(8'h0A, SYNC, 63);
        chk("max_M", int'(M), 63);

        // Bad character, then discard until terminator
        send_quiet("M1");
        send_byte("x", ERRP, 0);
        chk("err_busy", int'(Busy), 0);
        send_quiet("23");
        send_byte(8'h0D, NONE, 0);
        send_byte("7", SYNC, 7);
        chk("after_err_M", int'(M), 7);

        // Fourth digit overflows the frame
        send_quiet("M123");
        send_byte("4", ERRP, 0);
        send_byte(8'h0A, NONE, 0);
        chk("four_digit_M", int'(M), 7);

        // Timeout of a partial frame
        send_quiet("M12");
        repeat (30) @(negedge clk);
        chk("tmo_busy_before", int'(Busy), 1);
        repeat (15) @(negedge clk);
        chk("tmo_busy_after", int'(Busy), 0);
        send_byte(8'h0D, NONE, 0);
        chk("tmo_M_held", int'(M), 7);

        // Reset mid-frame
        send_byte("M", NONE, 0);
        busyR = 1'b1;
        rst   = 1'b1;
        m_model = M_W'(1);
        repeat (2) @(negedge clk);
        chk("midrst_M", int'(M), 1);
        chk("midrst_Busy", int'(Busy), 0);
        rst = 1'b0;
        send_byte("3", SYNC, 3);
        send_byte(8'h0D, NONE, 0);
        chk("midrst_final_M", int'(M), 3);

        busyR = 1'b1;
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
